// File: rtl/stash_serve_merge_arb.sv
// Packet-atomic 2:1 AXI-Stream merge: op0 (serve) has strict priority, op1 (stash) is forced after STARVE_LIMIT packets.
// Optional build macro STASH_MERGE_SRC_TAG_EN stamps the source id into m_axis_tuser[TAG_BIT].
module stash_serve_merge_arb #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned STARVE_LIMIT         = 4,
  parameter int unsigned CNT_WIDTH            = 4,
  parameter int unsigned TAG_BIT              = 127
) (
  input  logic                                axis_aclk,
  input  logic                                axis_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_op0_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_op0_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_op0_tuser,
  input  logic                                s_op0_tvalid,
  input  logic                                s_op0_tlast,
  output logic                                s_op0_tready,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_op1_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_op1_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_op1_tuser,
  input  logic                                s_op1_tvalid,
  input  logic                                s_op1_tlast,
  output logic                                s_op1_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,

  output logic [1:0]                          o_grant,
  output logic [CNT_WIDTH-1:0]                o_starve_cnt
);

  localparam int unsigned DATA_W = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned USER_W = C_S_AXIS_TUSER_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_OP0 = 2'd1,
    SEND_OP1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] starve_q, starve_d;
  logic [1:0]           grant_q, grant_d;
  logic                 rdy0, rdy1;
  logic                 load;
  logic                 sel;

  logic [DATA_W-1:0]    beat_data;
  logic [KEEP_W-1:0]    beat_keep;
  logic [USER_W-1:0]    beat_user;
  logic                 beat_last;
  logic                 tag;

  // State, starvation counter and grant registers
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      grant_q  <= grant_d;
    end
  end

  // Arbitration decisions in IDLE, packet forwarding in SEND_x
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    load     = 1'b0;
    sel      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_op1_tvalid && (!s_op0_tvalid || (starve_q == LIMIT))) begin
          state_d  = SEND_OP1;
          starve_d = '0;
        end else if (s_op0_tvalid) begin
          state_d = SEND_OP0;
          if (s_op1_tvalid && (starve_q != LIMIT)) begin
            starve_d = starve_q + CNT_WIDTH'(1);
          end
        end
      end
      SEND_OP0: begin
        rdy0 = !m_axis_tvalid || m_axis_tready;
        load = s_op0_tvalid && rdy0;
        if (load && s_op0_tlast) begin
          state_d = IDLE;
        end
      end
      SEND_OP1: begin
        sel  = 1'b1;
        rdy1 = !m_axis_tvalid || m_axis_tready;
        load = s_op1_tvalid && rdy1;
        if (load && s_op1_tlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant tracks the next state so it is registered alongside it
  always_comb begin
    grant_d = 2'b00;
    case (state_d)
      SEND_OP0: grant_d = 2'b01;
      SEND_OP1: grant_d = 2'b10;
      default:  grant_d = 2'b00;
    endcase
  end

`ifdef STASH_MERGE_SRC_TAG_EN
  assign tag = sel;
`else
  assign tag = sel ? s_op1_tuser[TAG_BIT] : s_op0_tuser[TAG_BIT];
`endif

  // Owner payload mux; the tag bit collapses to pass-through when tagging is off
  always_comb begin
    beat_data          = sel ? s_op1_tdata : s_op0_tdata;
    beat_keep          = sel ? s_op1_tkeep : s_op0_tkeep;
    beat_last          = sel ? s_op1_tlast : s_op0_tlast;
    beat_user          = sel ? s_op1_tuser : s_op0_tuser;
    beat_user[TAG_BIT] = tag;
  end

  // Egress register: loads on accept, holds under back-pressure
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= beat_data;
      m_axis_tkeep  <= beat_keep;
      m_axis_tuser  <= beat_user;
      m_axis_tlast  <= beat_last;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign s_op0_tready = rdy0;
  assign s_op1_tready = rdy1;
  assign o_grant      = grant_q;
  assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_stash_serve_merge_arb.sv
// Randomized self-checking bench for stash_serve_merge_arb against a packet-level arbitration model.
module tb_stash_serve_merge_arb;

  localparam int unsigned DW    = 256;
  localparam int unsigned KW    = 32;
  localparam int unsigned UW    = 128;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned TAG   = 127;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_op0_tdata, s_op1_tdata, m_axis_tdata;
  logic [KW-1:0] s_op0_tkeep, s_op1_tkeep, m_axis_tkeep;
  logic [UW-1:0] s_op0_tuser, s_op1_tuser, m_axis_tuser;
  logic          s_op0_tvalid, s_op0_tlast, s_op0_tready;
  logic          s_op1_tvalid, s_op1_tlast, s_op1_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    o_grant;
  logic [CW-1:0] o_starve_cnt;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            src;
  } beat_t;

  beat_t q0[$], q1[$], exp_q[$];
  int    len0[$], len1[$], dec_src[$], dec_cnt[$];
  int    n_chk = 0, n_fail = 0;
  int    rx_cnt, mon_cycles, ready_mode, first_cnt;
  bit    done, abort, gaps;
  logic [1:0] first_grant;

  always #5 clk = ~clk;

  stash_serve_merge_arb #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW), .TAG_BIT(TAG)
  ) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .s_op0_tdata(s_op0_tdata), .s_op0_tkeep(s_op0_tkeep), .s_op0_tuser(s_op0_tuser),
    .s_op0_tvalid(s_op0_tvalid), .s_op0_tlast(s_op0_tlast), .s_op0_tready(s_op0_tready),
    .s_op1_tdata(s_op1_tdata), .s_op1_tkeep(s_op1_tkeep), .s_op1_tuser(s_op1_tuser),
    .s_op1_tvalid(s_op1_tvalid), .s_op1_tlast(s_op1_tlast), .s_op1_tready(s_op1_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_grant(o_grant), .o_starve_cnt(o_starve_cnt)
  );

  task automatic clear_inputs();
    s_op0_tdata = '0; s_op0_tkeep = '0; s_op0_tuser = '0; s_op0_tvalid = 1'b0; s_op0_tlast = 1'b0;
    s_op1_tdata = '0; s_op1_tkeep = '0; s_op1_tuser = '0; s_op1_tvalid = 1'b0; s_op1_tlast = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q0.delete(); q1.delete(); len0.delete(); len1.delete();
  endtask

  task automatic gen(input int src, input int n, input int lmin, input int lmax);
    beat_t bt;
    int len;
    for (int p = 0; p < n; p++) begin
      len = int'($urandom_range(lmax, lmin));
      if (src == 0) len0.push_back(len); else len1.push_back(len);
      for (int b = 0; b < len; b++) begin
        bt.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        bt.keep = $urandom();
        bt.user = {$urandom(), $urandom(), $urandom(), $urandom()};
        bt.last = (b == len - 1);
        bt.src  = src;
        if (src == 0) q0.push_back(bt); else q1.push_back(bt);
      end
    end
  endtask

  // Packet-level model: every queued packet is pending at each decision point
  task automatic build_expected();
    int p0, p1, b0, b1, cnt, src, len;
    bit v0, v1;
    beat_t bt;
    p0 = 0; p1 = 0; b0 = 0; b1 = 0; cnt = 0;
    exp_q.delete(); dec_src.delete(); dec_cnt.delete();
    while (p0 < len0.size() || p1 < len1.size()) begin
      v0 = (p0 < len0.size());
      v1 = (p1 < len1.size());
      if (v1 && (!v0 || cnt == LIMIT)) begin
        src = 1; cnt = 0;
      end else begin
        src = 0;
        if (v1 && cnt < LIMIT) cnt++;
      end
      dec_src.push_back(src);
      dec_cnt.push_back(cnt);
      if (src == 0) begin len = len0[p0]; p0++; end else begin len = len1[p1]; p1++; end
      for (int b = 0; b < len; b++) begin
        if (src == 0) begin bt = q0[b0]; b0++; end else begin bt = q1[b1]; b1++; end
`ifdef STASH_MERGE_SRC_TAG_EN
        bt.user[TAG] = (src == 1);
`endif
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic put(input int src, input beat_t bt, input bit v);
    if (src == 0) begin
      s_op0_tdata = bt.data; s_op0_tkeep = bt.keep; s_op0_tuser = bt.user;
      s_op0_tlast = bt.last; s_op0_tvalid = v;
    end else begin
      s_op1_tdata = bt.data; s_op1_tkeep = bt.keep; s_op1_tuser = bt.user;
      s_op1_tlast = bt.last; s_op1_tvalid = v;
    end
  endtask

  task automatic drive(input int src);
    beat_t bt;
    bit fired, first;
    logic [1:0] eg;
    first = 1'b1;
    eg = (src == 0) ? 2'b01 : 2'b10;
    while (!abort && (((src == 0) ? q0.size() : q1.size()) > 0)) begin
      if (src == 0) bt = q0.pop_front(); else bt = q1.pop_front();
      if (gaps && !first && $urandom_range(3, 0) == 0) begin
        put(src, bt, 1'b0);
        repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
      end
      put(src, bt, 1'b1);
      fired = 1'b0;
      while (!fired && !abort) begin
        @(negedge clk);
        fired = (src == 0) ? (s_op0_tvalid && s_op0_tready) : (s_op1_tvalid && s_op1_tready);
        if (fired) begin
          n_chk++;
          if (o_grant !== eg) begin
            n_fail++;
            $display("FAIL grant_on_accept src%0d: o_grant=%b expected %b", src, o_grant, eg);
          end
        end
        @(posedge clk); #1;
        if (fired) begin
          n_chk++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== bt.data) begin
            n_fail++;
            $display("FAIL accept_latency src%0d: tvalid=%b data=%h expected tvalid=1 data=%h",
                     src, m_axis_tvalid, m_axis_tdata, bt.data);
          end
        end
      end
      first = bt.last;
    end
    if (src == 0) s_op0_tvalid = 1'b0; else s_op1_tvalid = 1'b0;
  endtask

  task automatic ready_gen();
    int ph;
    ph = 0;
    while (!done) begin
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(9, 0) < 7);
        default: m_axis_tready = ((ph % 4) == 0) || ((ph % 4) == 3);
      endcase
      ph++;
      @(posedge clk); #1;
    end
  endtask

  task automatic monitor(input int budget);
    beat_t e;
    int cyc, di;
    logic [1:0] pg, eg;
    bit ps;
    logic [DW-1:0] pd;
    logic pl;
    cyc = 0; di = 0; pg = 2'b00; ps = 1'b0; pd = '0; pl = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ps) begin
        n_chk++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
          n_fail++;
          $display("FAIL stall_hold: tvalid=%b data=%h last=%b expected tvalid=1 data=%h last=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0) begin
        n_chk++;
        if (s_op0_tready !== 1'b0 || s_op1_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_tready: op0=%b op1=%b expected 0 0", s_op0_tready, s_op1_tready);
        end
      end
      if (pg == 2'b00 && o_grant !== 2'b00) begin
        n_chk++;
        if (di >= dec_src.size()) begin
          n_fail++;
          $display("FAIL extra_decision: o_grant=%b expected no further grant", o_grant);
        end else begin
          eg = (dec_src[di] == 0) ? 2'b01 : 2'b10;
          if (di == 0) begin first_grant = o_grant; first_cnt = int'(o_starve_cnt); end
          if (o_grant !== eg || o_starve_cnt !== CW'(dec_cnt[di])) begin
            n_fail++;
            $display("FAIL decision%0d: grant=%b cnt=%0d expected grant=%b cnt=%0d",
                     di, o_grant, o_starve_cnt, eg, dec_cnt[di]);
          end
        end
        di++;
      end
      pg = o_grant;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        e = exp_q.pop_front();
        rx_cnt++;
        mon_cycles = cyc;
        n_chk++;
        if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
            m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
          n_fail++;
          $display("FAIL egress_beat%0d: data=%h user=%h last=%b expected data=%h user=%h last=%b",
                   rx_cnt, m_axis_tdata, m_axis_tuser, m_axis_tlast, e.data, e.user, e.last);
        end
      end
      ps = (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0);
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL egress_timeout: %0d beats outstanding expected 0", exp_q.size());
    end
    n_chk++;
    if (di != dec_src.size()) begin
      n_fail++;
      $display("FAIL decision_count: saw %0d expected %0d", di, dec_src.size());
    end
    done = 1'b1;
    abort = 1'b1;
  endtask

  task automatic run_traffic(input int mode, input bit g, input int budget);
    ready_mode = mode; gaps = g; done = 1'b0; abort = 1'b0;
    rx_cnt = 0; mon_cycles = 0; first_grant = 2'b00; first_cnt = -1;
    build_expected();
    fork
      drive(0);
      drive(1);
      monitor(budget);
      ready_gen();
    join
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    s_op0_tvalid = 1'b1; s_op1_tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 ||
        m_axis_tuser !== '0 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_egress: tvalid=%b tlast=%b data=%h expected all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    n_chk++;
    if (o_grant !== 2'b00 || o_starve_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b cnt=%0d expected 00 0", o_grant, o_starve_cnt);
    end
    n_chk++;
    if (s_op0_tready !== 1'b0 || s_op1_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready: op0=%b op1=%b expected 0 0", s_op0_tready, s_op1_tready);
    end
  endtask

  task automatic test_op0_only();
    do_reset();
    gen(0, 1, 3, 3);
    run_traffic(0, 1'b0, 200);
    n_chk++;
    if (rx_cnt != 3 || mon_cycles != 5 || o_starve_cnt !== '0) begin
      n_fail++;
      $display("FAIL op0_only: beats=%0d cycles=%0d cnt=%0d expected 3 5 0", rx_cnt, mon_cycles, o_starve_cnt);
    end
  endtask

  task automatic test_op1_only();
    do_reset();
    gen(1, 2, 2, 2);
    run_traffic(0, 1'b0, 200);
    n_chk++;
    if (rx_cnt != 4 || mon_cycles != 7 || first_grant !== 2'b10) begin
      n_fail++;
      $display("FAIL op1_only: beats=%0d cycles=%0d grant=%b expected 4 7 10", rx_cnt, mon_cycles, first_grant);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    gen(0, 10, 1, 1);
    gen(1, 3, 1, 1);
    run_traffic(0, 1'b0, 400);
    n_chk++;
    if (rx_cnt != 13 || mon_cycles != 27 || o_starve_cnt !== '0) begin
      n_fail++;
      $display("FAIL starvation: beats=%0d cycles=%0d cnt=%0d expected 13 27 0", rx_cnt, mon_cycles, o_starve_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gen(0, 1, 4, 4);
    run_traffic(2, 1'b0, 200);
    n_chk++;
    if (rx_cnt != 4 || o_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL backpressure: beats=%0d grant=%b expected 4 00", rx_cnt, o_grant);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    gen(0, 1, 2, 2);
    gen(1, 1, 2, 2);
    run_traffic(0, 1'b0, 200);
    n_chk++;
    if (first_grant !== 2'b01 || first_cnt != 1 || rx_cnt != 4) begin
      n_fail++;
      $display("FAIL simultaneous: grant=%b cnt=%0d beats=%0d expected 01 1 4", first_grant, first_cnt, rx_cnt);
    end
  endtask

  task automatic test_random();
    int total, fcnt;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      gen(0, int'($urandom_range(8, 1)), 1, 5);
      gen(1, int'($urandom_range(4, 1)), 1, 5);
      total = q0.size() + q1.size();
      run_traffic(1, 1'b1, 4000);
      fcnt = dec_cnt[dec_cnt.size() - 1];
      n_chk++;
      if (rx_cnt != total || o_starve_cnt !== CW'(fcnt) || o_grant !== 2'b00) begin
        n_fail++;
        $display("FAIL random_round%0d: beats=%0d cnt=%0d grant=%b expected %0d %0d 00",
                 r, rx_cnt, o_starve_cnt, o_grant, total, fcnt);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    beat_t pk[5];
    beat_t b1;
    int fires, cyc;
    bit f;
    do_reset();
    gen(0, 1, 5, 5);
    gen(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) pk[i] = q0[i];
    b1 = q1[0];
    m_axis_tready = 1'b1;
    put(0, pk[0], 1'b1);
    put(1, b1, 1'b1);
    fires = 0; cyc = 0;
    while (fires < 2 && cyc < 40) begin
      @(negedge clk);
      f = s_op0_tvalid && s_op0_tready;
      @(posedge clk); #1;
      if (f) begin
        fires++;
        put(0, pk[fires], 1'b1);
      end
      cyc++;
    end
    n_chk++;
    if (fires != 2 || o_grant !== 2'b01 || o_starve_cnt !== CW'(1) || m_axis_tdata !== pk[1].data) begin
      n_fail++;
      $display("FAIL pre_reset: fires=%0d grant=%b cnt=%0d expected 2 01 1", fires, o_grant, o_starve_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (m_axis_tvalid !== 1'b0 || o_grant !== 2'b00 || o_starve_cnt !== '0 ||
        s_op0_tready !== 1'b0 || s_op1_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: tvalid=%b grant=%b cnt=%0d rdy0=%b rdy1=%b expected 0 00 0 0 0",
               m_axis_tvalid, o_grant, o_starve_cnt, s_op0_tready, s_op1_tready);
    end
    rst = 1'b0;
    s_op0_tvalid = 1'b0; s_op1_tvalid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (m_axis_tvalid !== 1'b0 || o_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: tvalid=%b grant=%b expected 0 00", m_axis_tvalid, o_grant);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_op0_only();
    test_op1_only();
    test_starvation();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
